// File: rtl/spiker_run_ctrl.sv
// Run sequencer for one spiker inference: streams the input words into the core,
// starts it, watches for done under a watchdog and strobes the result latch.
module spiker_run_ctrl #(
    parameter int WIDTH          = 32,
    parameter int N_IN_WORDS     = 25,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int IDX_W          = $clog2(N_IN_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [IDX_W-1:0] in_idx_o,
    input  logic [WIDTH-1:0] in_word_i,
    output logic [WIDTH-1:0] core_data_o,
    output logic             core_valid_o,
    input  logic             core_ready_i,
    output logic             core_start_o,
    input  logic             core_done_i,
    output logic             sample_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             aborted_o,
    output logic             irq_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             done_r, done_s;
    logic             tmo_r, tmo_s;
    logic             abt_r, abt_s;

    // Next-state, index, watchdog and sticky-flag logic
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        done_s  = done_r;
        tmo_s   = tmo_r;
        abt_s   = abt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    done_s  = 1'b0;
                    tmo_s   = 1'b0;
                    abt_s   = 1'b0;
                    idx_s   = {IDX_W{1'b0}};
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    abt_s   = 1'b1;
                    state_s = ST_FINISH;
                end else if (core_ready_i) begin
                    if (idx_r == LAST_IDX) begin
                        idx_s   = {IDX_W{1'b0}};
                        state_s = ST_START;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_START: begin
                if (abort_i) begin
                    abt_s   = 1'b1;
                    state_s = ST_FINISH;
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_s = cnt_r + CNT_W'(1);
                // abort beats done, done beats the watchdog
                if (abort_i) begin
                    abt_s   = 1'b1;
                    state_s = ST_FINISH;
                end else if (core_done_i) begin
                    state_s = ST_SAMPLE;
                end else if (cnt_r == LAST_CNT) begin
                    tmo_s   = 1'b1;
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SAMPLE: begin
                done_s  = 1'b1;
                state_s = ST_FINISH;
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
            tmo_r   <= 1'b0;
            abt_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
            tmo_r   <= tmo_s;
            abt_r   <= abt_s;
        end
    end

    assign in_idx_o     = idx_r;
    assign core_valid_o = (state_r == ST_LOAD);
    assign core_data_o  = (state_r == ST_LOAD) ? in_word_i : {WIDTH{1'b0}};
    assign core_start_o = (state_r == ST_START) && !abort_i;
    assign sample_o     = (state_r == ST_SAMPLE);
    assign irq_o        = (state_r == ST_FINISH);
    assign busy_o       = (state_r != ST_IDLE);
    assign done_o       = done_r;
    assign timeout_o    = tmo_r;
    assign aborted_o    = abt_r;

endmodule
